// File: rtl/seg7_mmss_display_pkg.sv
// Shared constants for the seven-segment display blocks: digit slots and
// active-low gfedcba segment patterns.
package seg7_mmss_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DP_DIGIT   = 2;
  localparam int DIG_S0     = 0;
  localparam int DIG_S1     = 1;
  localparam int DIG_M0     = 2;
  localparam int DIG_M1     = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_mmss_display_bcd_to_seg7.sv
// BCD digit to active-low gfedcba segments; non-decimal codes blank the digit.
module bcd_to_seg7
  import seg7_mmss_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_mmss_display.sv
// Elapsed-time MM:SS counter driven by a 1 Hz data input, shown on a
// 4-digit multiplexed active-low seven-segment display.
module seg7_mmss_display
  import seg7_mmss_display_pkg::*;
#(
  parameter int REFRESH_COUNT = 99_999
) (
  input  logic       i_clk_100MHz,
  input  logic       i_rst,
  input  logic       i_clk_1Hz,
  input  logic       i_pause,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [3:0] o_an,
  output logic       o_tick
);
  localparam int RW = (REFRESH_COUNT > 0) ? $clog2(REFRESH_COUNT + 1) : 1;
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_COUNT);

  logic          sync1_q, sync2_q, sync3_q;
  logic [3:0]    s0_q, s1_q, m0_q, m1_q;
  logic [3:0]    s0_d, s1_d, m0_d, m1_d;
  logic          tick_d;
  logic [RW-1:0] ref_q;
  logic [1:0]    idx_q;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic          rise;

  assign rise = sync2_q & ~sync3_q;

  // Ripple-carry through the four BCD digits on each counted second.
  always_comb begin
    s0_d   = s0_q;
    s1_d   = s1_q;
    m0_d   = m0_q;
    m1_d   = m1_q;
    tick_d = 1'b0;
    if (rise && !i_pause) begin
      tick_d = 1'b1;
      if (s0_q == 4'd9) begin
        s0_d = 4'd0;
        if (s1_q == 4'd5) begin
          s1_d = 4'd0;
          if (m0_q == 4'd9) begin
            m0_d = 4'd0;
            m1_d = (m1_q == 4'd5) ? 4'd0 : m1_q + 4'd1;
          end else begin
            m0_d = m0_q + 4'd1;
          end
        end else begin
          s1_d = s1_q + 4'd1;
        end
      end else begin
        s0_d = s0_q + 4'd1;
      end
    end
  end

  always_comb begin
    case (idx_q)
      2'(DIG_S0): cur_digit = s0_q;
      2'(DIG_S1): cur_digit = s1_q;
      2'(DIG_M0): cur_digit = m0_q;
      default:    cur_digit = m1_q;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_seg)
  );

  always_ff @(posedge i_clk_100MHz) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      s0_q    <= 4'd0;
      s1_q    <= 4'd0;
      m0_q    <= 4'd0;
      m1_q    <= 4'd0;
      ref_q   <= '0;
      idx_q   <= 2'd0;
      o_tick  <= 1'b0;
      o_an    <= 4'b1110;
      o_seg   <= SEG_0;
      o_dp    <= 1'b1;
    end else begin
      sync1_q <= i_clk_1Hz;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      o_tick  <= tick_d;
      if (ref_q == REF_MAX) begin
        ref_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        ref_q <= ref_q + RW'(1);
      end
      // Decimal point on the m0 slot stands in for the MM:SS colon.
      o_an  <= ~(4'b0001 << idx_q);
      o_seg <= cur_seg;
      o_dp  <= (idx_q != 2'(DP_DIGIT));
    end
  end
endmodule

// File: tb/tb_seg7_mmss_display.sv
// Directed bench for seg7_mmss_display with a short refresh slot.
module tb_seg7_mmss_display;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hz = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       tick;

  int total = 0;
  int passed = 0;
  int ticks = 0;

  seg7_mmss_display #(.REFRESH_COUNT(3)) dut (
    .i_clk_100MHz (clk),
    .i_rst        (rst),
    .i_clk_1Hz    (hz),
    .i_pause      (pause),
    .o_seg        (seg),
    .o_dp         (dp),
    .o_an         (an),
    .o_tick       (tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tick === 1'b1) ticks++;

  logic [6:0] SEGP [10];

  typedef struct {
    string name;
    int    edges;
    int    m1, m0, s1, s0;
    int    exp_ticks;
  } vec_t;

  vec_t vecs [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hz = 1'b1;
    @(negedge clk);
    hz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      hz = 1'b1;
      repeat (3) @(negedge clk);
      hz = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic read_dig(input int i, output logic [6:0] s);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << i);
    n = 0;
    while (an !== want && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      $display("FAIL scan_wait: anode %b never seen, o_an=%b", want, an);
    end
    s = seg;
  endtask

  task automatic check_disp(input string nm, input int m1, input int m0, input int s1, input int s0);
    logic [6:0] s;
    read_dig(0, s); chk({nm, "_s0"}, 32'(s), 32'(SEGP[s0]));
    read_dig(1, s); chk({nm, "_s1"}, 32'(s), 32'(SEGP[s1]));
    read_dig(2, s); chk({nm, "_m0"}, 32'(s), 32'(SEGP[m0]));
    read_dig(3, s); chk({nm, "_m1"}, 32'(s), 32'(SEGP[m1]));
  endtask

  initial begin
    int base;
    int n;
    logic [3:0] pats [4];
    SEGP[0] = 7'b1000000; SEGP[1] = 7'b1111001; SEGP[2] = 7'b0100100;
    SEGP[3] = 7'b0110000; SEGP[4] = 7'b0011001; SEGP[5] = 7'b0010010;
    SEGP[6] = 7'b0000010; SEGP[7] = 7'b1111000; SEGP[8] = 7'b0000000;
    SEGP[9] = 7'b0010000;
    vecs[0] = '{"roll_00_10",    9, 0, 0, 1, 0,   10};
    vecs[1] = '{"roll_01_00",   50, 0, 1, 0, 0,   60};
    vecs[2] = '{"roll_00_00", 3540, 0, 0, 0, 0, 3600};
    pats[0] = 4'b1101; pats[1] = 4'b1011; pats[2] = 4'b0111; pats[3] = 4'b1110;

    // Reset with the 1 Hz input toggling
    @(negedge clk);
    rst = 1'b1;
    hz = 1'b1;
    @(negedge clk);
    hz = 1'b0;
    @(negedge clk);
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    chk("rst_dp", 32'(dp), 32'(1'b1));
    chk("rst_tick", 32'(tick), 32'(1'b0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    ticks = 0;
    check_disp("rst_disp", 0, 0, 0, 0);

    // Single rising edge: exact tick latency, falling edge ignored
    base = ticks;
    hz = 1'b1;
    @(negedge clk); chk("lat_k", 32'(tick), 32'(1'b0));
    @(negedge clk); chk("lat_k1", 32'(tick), 32'(1'b0));
    @(negedge clk); chk("lat_k2", 32'(tick), 32'(1'b1));
    @(negedge clk); chk("lat_k3", 32'(tick), 32'(1'b0));
    hz = 1'b0;
    repeat (8) @(negedge clk);
    chk("single_ticks", 32'(ticks - base), 32'd1);
    check_disp("single_disp", 0, 0, 0, 1);

    // Scan order, slot length and decimal point
    n = 0;
    while (an !== 4'b1101 && n < 50) begin @(negedge clk); n++; end
    chk("scan_sync", 32'(an), 32'(4'b1101));
    for (int p = 0; p < 4; p++) begin
      int len;
      int dpbad;
      len = 0;
      dpbad = 0;
      while (an === pats[p] && len < 20) begin
        if (dp !== (pats[p] == 4'b1011 ? 1'b0 : 1'b1)) dpbad++;
        len++;
        @(negedge clk);
      end
      chk($sformatf("scan_len_%b", pats[p]), 32'(len), 32'd4);
      chk($sformatf("scan_dp_%b", pats[p]), 32'(dpbad), 32'd0);
    end
    chk("scan_wrap", 32'(an), 32'(4'b1101));

    // Roll-over table, cumulative from the reset above
    for (int v = 0; v < 3; v++) begin
      pulse(vecs[v].edges);
      chk({vecs[v].name, "_ticks"}, 32'(ticks), 32'(vecs[v].exp_ticks));
      check_disp(vecs[v].name, vecs[v].m1, vecs[v].m0, vecs[v].s1, vecs[v].s0);
    end

    // Pause drops the edge permanently
    do_reset();
    pulse(5);
    check_disp("pre_pause", 0, 0, 0, 5);
    base = ticks;
    pause = 1'b1;
    pulse(1);
    pause = 1'b0;
    repeat (4) @(negedge clk);
    chk("pause_ticks", 32'(ticks - base), 32'd0);
    check_disp("pause_hold", 0, 0, 0, 5);
    pulse(1);
    check_disp("after_pause", 0, 0, 0, 6);

    // Reset coincident with a pending rise at 12:34
    do_reset();
    pulse(754);
    check_disp("pre_rst", 1, 2, 3, 4);
    base = ticks;
    hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tick", 32'(tick), 32'(1'b0));
    chk("midrst_an", 32'(an), 32'(4'b1110));
    chk("midrst_seg", 32'(seg), 32'(7'b1000000));
    rst = 1'b0;
    hz = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_ticks", 32'(ticks - base), 32'd0);
    check_disp("midrst_disp", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
